icache_tag_ctrl: RTL and testbench

- Initiator-side controller for the L1.5 icache tag RAM. It drives the single-port tag RAM's req/write/addr/wdata and consumes its rdata.
- Arbitrates three request sources against that one port:
  - tag lookups from the fetch pipeline;
  - refill tag writes from the refill engine;
  - full-cache flushes.
- Each lookup produces a registered-latency hit/miss result.
- Runs a mandatory invalidation sweep after reset, because tag RAM contents are undefined at power-up.

---
 rtl/icache_tag_pkg.sv | 58 +++++
 rtl/icache_tag_ctrl.sv | 147 ++++++++++++++
 tb/tb_icache_tag_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_tag_pkg.sv
// Shared types and helpers for the icache tag RAM controller.
// Holds the controller state encoding, the default geometry of the tag RAM,
// the position of the valid bit and pack/unpack helpers for {valid, tag}
// words. The helpers work on a 32-bit scratch word and take the tag width as
// an argument, so a parameterised instance can reuse them without a
// package per geometry.
package icache_tag_pkg;

    // Default geometry: 64 sets, 6-bit tags, one valid bit on top.
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_TAG_WIDTH  = 6;

    // The valid bit sits directly above the tag field.
    localparam int unsigned VALID_BIT      = DEF_TAG_WIDTH;
    localparam int unsigned DEF_DATA_WIDTH = VALID_BIT + 1;

    // Scratch widths used by the pack/unpack helpers.
    localparam int unsigned ENTRY_MAX_W = 32;
    localparam int unsigned TAG_MAX_W   = ENTRY_MAX_W - 1;

    // Controller states.
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FLUSH = 2'd1,
        S_IDLE  = 2'd2
    } state_e;

    // Build a {valid, tag} word; tag must already be zero-extended.
    function automatic logic [ENTRY_MAX_W-1:0] pack_entry(
        input logic                 valid,
        input logic [TAG_MAX_W-1:0] tag,
        input int unsigned          tag_w
    );
        logic [ENTRY_MAX_W-1:0] e;
        e           = ENTRY_MAX_W'(tag);
        e[5'(tag_w)] = valid;
        return e;
    endfunction

    // Extract the valid bit of a zero-extended tag RAM word.
    function automatic logic entry_valid(
        input logic [ENTRY_MAX_W-1:0] word,
        input int unsigned            tag_w
    );
        return word[5'(tag_w)];
    endfunction

    // Extract the tag field of a zero-extended tag RAM word.
    function automatic logic [TAG_MAX_W-1:0] entry_tag(
        input logic [ENTRY_MAX_W-1:0] word,
        input int unsigned            tag_w
    );
        logic [ENTRY_MAX_W-1:0] mask;
        mask = (ENTRY_MAX_W'(1) << tag_w) - ENTRY_MAX_W'(1);
        return TAG_MAX_W'(word & mask);
    endfunction

endpackage

// File: rtl/icache_tag_ctrl.sv
// Initiator-side controller for the L1.5 icache tag RAM.
// Arbitrates flush > refill > lookup onto a single-port tag RAM, returns a
// registered-latency hit/miss result per lookup and runs an invalidation
// sweep of every set after reset and on each flush request.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lookup_*            fetch-side lookup: req/index/tag in, gnt/rvalid/hit out
//   refill_*            refill tag write: req/index/tag in, gnt out
//   flush_req_i         level request to invalidate all sets (ignored while busy)
//   flush_done_o        one-cycle pulse in the first IDLE cycle after a sweep
//   busy_o              high across INIT, FLUSH and the sweep-done cycle
//   tag_req_o/write_o/addr_o/wdata_o, tag_rdata_i   tag RAM port
module icache_tag_ctrl
    import icache_tag_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = TAG_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  lookup_req_i,
    input  logic [ADDR_WIDTH-1:0] lookup_index_i,
    input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
    output logic                  lookup_gnt_o,
    output logic                  lookup_rvalid_o,
    output logic                  lookup_hit_o,

    input  logic                  refill_req_i,
    input  logic [ADDR_WIDTH-1:0] refill_index_i,
    input  logic [TAG_WIDTH-1:0]  refill_tag_i,
    output logic                  refill_gnt_o,

    input  logic                  flush_req_i,
    output logic                  flush_done_o,
    output logic                  busy_o,

    output logic                  tag_req_o,
    output logic                  tag_write_o,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic [DATA_WIDTH-1:0] tag_wdata_o,
    input  logic [DATA_WIDTH-1:0] tag_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    flush_done_q, flush_done_d;
    logic                    rvalid_q, rvalid_d;
    logic [TAG_WIDTH-1:0]    ltag_q, ltag_d;

    // Next-state, arbitration and tag RAM drive.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        lookup_gnt_o = 1'b0;
        refill_gnt_o = 1'b0;
        tag_req_o    = 1'b0;
        tag_write_o  = 1'b0;
        tag_addr_o   = '0;
        tag_wdata_o  = '0;

        case (state_q)
            S_INIT: begin
                // RAM contents are undefined; sweep before serving anyone.
                state_d = S_FLUSH;
                cnt_d   = '0;
            end

            S_FLUSH: begin
                tag_req_o   = 1'b1;
                tag_write_o = 1'b1;
                tag_addr_o  = cnt_q;
                cnt_d       = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_MAX) begin
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end
            end

            S_IDLE: begin
                if (flush_req_i) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (refill_req_i && !rst) begin
                    refill_gnt_o = 1'b1;
                    tag_req_o    = 1'b1;
                    tag_write_o  = 1'b1;
                    tag_addr_o   = refill_index_i;
                    tag_wdata_o  = DATA_WIDTH'(pack_entry(1'b1, TAG_MAX_W'(refill_tag_i), TAG_WIDTH));
                end else if (lookup_req_i && !rst) begin
                    lookup_gnt_o = 1'b1;
                    tag_req_o    = 1'b1;
                    tag_addr_o   = lookup_index_i;
                end
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        // Busy stays up through the cycle that reports sweep completion.
        busy_d   = (state_d != S_IDLE) || (state_q != S_IDLE);
        rvalid_d = lookup_gnt_o;
        ltag_d   = lookup_gnt_o ? lookup_tag_i : ltag_q;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            flush_done_q <= 1'b0;
            rvalid_q     <= 1'b0;
            ltag_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            flush_done_q <= flush_done_d;
            rvalid_q     <= rvalid_d;
            ltag_q       <= ltag_d;
        end
    end

    // Hit compare against the RAM word returned in the rvalid cycle.
    always_comb begin
        logic [ENTRY_MAX_W-1:0] rd_word;
        rd_word      = ENTRY_MAX_W'(tag_rdata_i);
        lookup_hit_o = rvalid_q
                     & entry_valid(rd_word, TAG_WIDTH)
                     & (TAG_WIDTH'(entry_tag(rd_word, TAG_WIDTH)) == ltag_q);
    end

    assign lookup_rvalid_o = rvalid_q;
    assign flush_done_o    = flush_done_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural tag RAM and a
// lookup-result scoreboard.
module tb_icache_tag_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned TW    = 6;
    localparam int unsigned DW    = TW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lookup_req_i = 1'b0;
    logic [AW-1:0] lookup_index_i = '0;
    logic [TW-1:0] lookup_tag_i = '0;
    logic          lookup_gnt_o, lookup_rvalid_o, lookup_hit_o;
    logic          refill_req_i = 1'b0;
    logic [AW-1:0] refill_index_i = '0;
    logic [TW-1:0] refill_tag_i = '0;
    logic          refill_gnt_o;
    logic          flush_req_i = 1'b0;
    logic          flush_done_o, busy_o;
    logic          tag_req_o, tag_write_o;
    logic [AW-1:0] tag_addr_o;
    logic [DW-1:0] tag_wdata_o;
    logic [DW-1:0] tag_rdata_i = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit    hit;
        int    cyc;
        string nm;
    } sb_t;
    sb_t sb_q[$];

    icache_tag_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_req_i    (lookup_req_i),
        .lookup_index_i  (lookup_index_i),
        .lookup_tag_i    (lookup_tag_i),
        .lookup_gnt_o    (lookup_gnt_o),
        .lookup_rvalid_o (lookup_rvalid_o),
        .lookup_hit_o    (lookup_hit_o),
        .refill_req_i    (refill_req_i),
        .refill_index_i  (refill_index_i),
        .refill_tag_i    (refill_tag_i),
        .refill_gnt_o    (refill_gnt_o),
        .flush_req_i     (flush_req_i),
        .flush_done_o    (flush_done_o),
        .busy_o          (busy_o),
        .tag_req_o       (tag_req_o),
        .tag_write_o     (tag_write_o),
        .tag_addr_o      (tag_addr_o),
        .tag_wdata_o     (tag_wdata_o),
        .tag_rdata_i     (tag_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port tag RAM; powers up with valid garbage whose tag equals the index.
    logic [DW-1:0] mem [DEPTH];
    logic          ram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= {1'b1, TW'(i)};
            ram_seeded <= 1'b1;
        end else if (tag_req_o) begin
            if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
            else             tag_rdata_i     <= mem[tag_addr_o];
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    // Scoreboard: every rvalid pops one expected result and its due cycle.
    always @(negedge clk) begin
        if (lookup_rvalid_o) begin
            if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(1), 32'(0));
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk({e.nm, "_hit"}, 32'(lookup_hit_o), 32'(e.hit));
                chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic logic [31:0] reset_vec();
        return 32'({lookup_gnt_o, lookup_rvalid_o, lookup_hit_o, refill_gnt_o,
                    flush_done_o, busy_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o});
    endfunction
    localparam logic [31:0] RESET_EXP = 32'(1) << (AW + DW + 2);

    task automatic clr_reqs();
        lookup_req_i = 1'b0;
        refill_req_i = 1'b0;
        flush_req_i  = 1'b0;
    endtask

    task automatic do_refill(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                             input int max_wait, input string nm);
        int waited = 0;
        @(negedge clk);
        clr_reqs();
        refill_req_i = 1'b1; refill_index_i = idx; refill_tag_i = tag;
        #1;
        while (!refill_gnt_o && waited < max_wait) begin
            @(negedge clk); #1; waited++;
        end
        chk({nm, "_gnt"}, 32'(refill_gnt_o), 32'(1));
        if (refill_gnt_o)
            chk({nm, "_ram"}, 32'({tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o}),
                32'({1'b1, 1'b1, idx, 1'b1, tag}));
    endtask

    task automatic do_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                             input bit exp_hit, input int max_wait, input string nm);
        int waited = 0;
        @(negedge clk);
        clr_reqs();
        lookup_req_i = 1'b1; lookup_index_i = idx; lookup_tag_i = tag;
        #1;
        while (!lookup_gnt_o && waited < max_wait) begin
            @(negedge clk); #1; waited++;
        end
        chk({nm, "_gnt"}, 32'(lookup_gnt_o), 32'(1));
        if (lookup_gnt_o) begin
            chk({nm, "_ram"}, 32'({tag_req_o, tag_write_o, tag_addr_o}), 32'({1'b1, 1'b0, idx}));
            sb_q.push_back('{hit: exp_hit, cyc: cyc + 1, nm: nm});
        end
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clr_reqs();
        end
    endtask

    // Called in the INIT cycle right after reset release.
    task automatic check_sweep(input string nm);
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk); #1;
            chk($sformatf("%s_wr%0d", nm, i),
                32'({tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o, busy_o, flush_done_o,
                     lookup_gnt_o, refill_gnt_o}),
                32'({1'b1, 1'b1, AW'(i), DW'(0), 1'b1, 1'b0, 1'b0, 1'b0}));
        end
        @(negedge clk); #1;
        chk({nm, "_done"}, 32'({flush_done_o, busy_o, tag_req_o}), 32'({1'b1, 1'b1, 1'b0}));
        @(negedge clk); #1;
        chk({nm, "_after"}, 32'({flush_done_o, busy_o}), 32'({1'b0, 1'b0}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state with requests pending: no grants, busy high.
        lookup_req_i = 1'b1;
        refill_req_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", reset_vec(), RESET_EXP);
        @(negedge clk);
        clr_reqs();
        rst = 1'b0;
        #1;
        chk("init_cycle", 32'({busy_o, tag_req_o, flush_done_o}), 32'({1'b1, 1'b0, 1'b0}));
        check_sweep("sweep0");

        // Refill then hit / miss on the same set.
        do_refill(5, 6'h2A, 0, "rf5");
        do_lookup(5, 6'h2A, 1'b1, 0, "lk5_hit");
        do_lookup(5, 6'h2B, 1'b0, 0, "lk5_miss");

        // Read in cycle N, refill same set in N+1: old contents returned.
        do_lookup(5, 6'h2A, 1'b1, 0, "lk5_pre");
        do_refill(5, 6'h15, 0, "rf5b");
        do_lookup(5, 6'h15, 1'b1, 0, "lk5_new");

        // Refill wins over a simultaneous lookup; lookup follows and hits.
        @(negedge clk);
        clr_reqs();
        refill_req_i = 1'b1; refill_index_i = 9; refill_tag_i = 6'h33;
        lookup_req_i = 1'b1; lookup_index_i = 9; lookup_tag_i = 6'h33;
        #1;
        chk("prio_gnts", 32'({refill_gnt_o, lookup_gnt_o}), 32'({1'b1, 1'b0}));
        do_lookup(9, 6'h33, 1'b1, 0, "lk9");

        // Back-to-back lookups of sets 1..4 with only set 2 refilled.
        do_refill(2, 6'h22, 0, "rf2");
        do_lookup(1, 6'h01, 1'b0, 0, "b2b1");
        do_lookup(2, 6'h22, 1'b1, 0, "b2b2");
        do_lookup(3, 6'h03, 1'b0, 0, "b2b3");
        do_lookup(4, 6'h04, 1'b0, 0, "b2b4");
        do_idle(2);

        // Flush with a lookup held pending throughout.
        do_refill(7, 6'h11, 0, "rf7");
        @(negedge clk);
        clr_reqs();
        flush_req_i  = 1'b1;
        lookup_req_i = 1'b1; lookup_index_i = 7; lookup_tag_i = 6'h11;
        #1;
        chk("flush_req_cycle", 32'({lookup_gnt_o, refill_gnt_o, tag_req_o, busy_o}), 32'(0));
        @(negedge clk);
        flush_req_i = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("flush_wr%0d", i),
                32'({lookup_gnt_o, busy_o, flush_done_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o}),
                32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b1, AW'(i), DW'(0)}));
        end
        @(negedge clk); #1;
        chk("flush_done", 32'({flush_done_o, busy_o, lookup_gnt_o}), 32'({1'b1, 1'b1, 1'b1}));
        if (lookup_gnt_o) sb_q.push_back('{hit: 1'b0, cyc: cyc + 1, nm: "lk7_flushed"});
        @(negedge clk);
        clr_reqs();
        #1;
        chk("flush_after", 32'({flush_done_o, busy_o}), 32'(0));

        // Reset in the middle of a sweep restarts it from set 0.
        do_refill(12, 6'h3C, 0, "rf12");
        @(negedge clk);
        clr_reqs();
        flush_req_i = 1'b1;
        @(negedge clk);
        flush_req_i = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            if (i != 0) @(negedge clk);
            #1;
        end
        chk("mid_flush_addr", 32'(tag_addr_o), 32'(30));
        lookup_req_i = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_reset", reset_vec(), RESET_EXP);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_hold", reset_vec(), RESET_EXP);
        @(negedge clk);
        clr_reqs();
        rst = 1'b0;
        #1;
        chk("init_cycle2", 32'({busy_o, tag_req_o}), 32'({1'b1, 1'b0}));
        check_sweep("sweep1");

        // Set refilled before the reset is gone after the restarted sweep.
        do_lookup(12, 6'h3C, 1'b0, 0, "lk12_reset");
        do_idle(3);
        chk("sb_drain", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
